instruction_fetch_unit: RTL

Fetch stage that consumes the program counter path and feeds decode. It holds the 64-bit PC, issues one instruction-memory read at a time, and registers the returned instruction with its PC. It presents that instruction to decode through a valid/ready handshake, then advances the PC by 4. Control flow changes arrive through a redirect input, which loads a new PC and discards any in-flight fetch.

---
 rtl/instruction_fetch_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch stage: holds the PC, issues one instruction-memory read at a time,
//   registers the returned word with its PC and hands it to decode over a
//   valid/ready handshake, then advances the PC by 4. A redirect loads a new
//   PC and discards whatever fetch is in flight.
// Ports:
//   clock, reset            rising-edge clock, async active-low reset
//   imem_req_valid/addr     read request (addr is always the current PC)
//   imem_req_ready          memory accepts the request
//   imem_resp_valid/data    read response
//   redirect_valid/pc       control-flow change, highest priority
//   out_valid/ready         handshake to decode
//   out_instr/out_pc        registered instruction and its PC
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          INSTR_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req_valid,
  output logic [63:0]            imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_resp_data,
  input  logic                   redirect_valid,
  input  logic [63:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [63:0]            out_pc
);

  // REQ: request presented; WAIT: response owed to us;
  // HOLD: instruction offered to decode; DROP: response owed but cancelled.
  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_e;

  state_e                 state_q, state_d;
  logic [63:0]            pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [63:0]            opc_q, opc_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    case (state_q)
      REQ: begin
        // A request accepted in the same cycle as a redirect still owes a
        // response, which must be swallowed in DROP.
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = imem_req_ready ? DROP : REQ;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = imem_resp_valid ? REQ : DROP;
        end else if (imem_resp_valid) begin
          instr_d = imem_resp_data;
          opc_d   = pc_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // With a redirect the transfer (if out_ready) still completes; only
        // the source of the next PC changes.
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else if (out_ready) begin
          pc_d    = pc_q + 64'd4;
          state_d = REQ;
        end
      end
      DROP: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (imem_resp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  // Reset resets the state to REQ, so gate the request with the reset pin
  // to keep it low while reset is held.
  assign imem_req_valid = reset && (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign out_valid      = (state_q == HOLD);
  assign out_instr      = instr_q;
  assign out_pc         = opc_q;

endmodule
